// File: rtl/adder_pkg.sv
// Shared arithmetic helpers for the pipelined datapath blocks (adder now, mul/acc later).
// Holds chunk sizing, the stage-divisibility check and the full-adder cell.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Per-stage control fields carried alongside the data words.
  localparam int STAGE_VALID_BITS = 1;
  localparam int STAGE_CARRY_BITS = 1;

  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 0;
  endfunction

  function automatic bit stages_divide(input int width, input int stages);
    return (stages > 0) && (width >= stages) && ((width % stages) == 0);
  endfunction

  // Stage record: valid, carry, partial sum and both operand words.
  function automatic int stage_record_bits(input int width);
    return STAGE_VALID_BITS + STAGE_CARRY_BITS + (3 * width);
  endfunction

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple adder slice built from full-adder cells.
// One instance per pipeline stage; carry enters from the previous stage.
module adder_slice
  import adder_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_ci,
  output logic [CHUNK-1:0] o_s,
  output logic             o_co
);

  // Ripple the carry LSB-first through the cells.
  always_comb begin
    logic [1:0] w_fa;
    logic       w_c;
    w_c = i_ci;
    o_s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_fa   = full_add(i_a[i], i_b[i], w_c);
      o_s[i] = w_fa[0];
      w_c    = w_fa[1];
    end
    o_co = w_c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES carry-chained slices, one slice per stage,
// with valid/ready streaming on both sides and a bubble-collapsing ready chain.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!stages_divide(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0]            w_valid_q;
  logic [STAGES-1:0]            w_carry_q;
  logic [STAGES-1:0]            w_rdy;
  logic [STAGES-1:0][WIDTH-1:0] w_a_q;
  logic [STAGES-1:0][WIDTH-1:0] w_b_q;
  logic [STAGES-1:0][WIDTH-1:0] w_sum_q;
  logic                         w_unused_ops;

  // Stage k may load when it is empty or anything downstream can move.
  always_comb begin
    logic w_run;
    w_run = out_ready;
    w_rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_run    = w_run | ~w_valid_q[k];
      w_rdy[k] = w_run;
    end
  end

  assign in_ready = w_rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_sum_in;
    logic [WIDTH-1:0] w_sum_new;
    logic [CHUNK-1:0] w_s;
    logic             w_c_in;
    logic             w_v_in;
    logic             w_co;
    logic             r_valid;
    logic             r_c;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;

    if (k == 0) begin : g_head
      assign w_a_in   = a;
      assign w_b_in   = b;
      assign w_sum_in = '0;
      assign w_c_in   = cin;
      assign w_v_in   = in_valid & w_rdy[0];
    end else begin : g_body
      assign w_a_in   = w_a_q[k-1];
      assign w_b_in   = w_b_q[k-1];
      assign w_sum_in = w_sum_q[k-1];
      assign w_c_in   = w_carry_q[k-1];
      assign w_v_in   = w_valid_q[k-1];
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .i_a  (w_a_in[k*CHUNK +: CHUNK]),
      .i_b  (w_b_in[k*CHUNK +: CHUNK]),
      .i_ci (w_c_in),
      .o_s  (w_s),
      .o_co (w_co)
    );

    // Splice this stage's chunk into the partial sum handed down the pipe.
    always_comb begin
      w_sum_new                     = w_sum_in;
      w_sum_new[k*CHUNK +: CHUNK]   = w_s;
    end

    // Stage register; data only moves with a valid entry so an empty output keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_c     <= 1'b0;
        r_a     <= '0;
        r_b     <= '0;
        r_sum   <= '0;
      end else if (w_rdy[k]) begin
        r_valid <= w_v_in;
        if (w_v_in) begin
          r_c   <= w_co;
          r_a   <= w_a_in;
          r_b   <= w_b_in;
          r_sum <= w_sum_new;
        end
      end
    end

    assign w_valid_q[k] = r_valid;
    assign w_carry_q[k] = r_c;
    assign w_a_q[k]     = r_a;
    assign w_b_q[k]     = r_b;
    assign w_sum_q[k]   = r_sum;

    if (k == STAGES - 1) begin : g_tail
      logic r_ovf;

      // Overflow needs the final sum MSB, so it is resolved as the last chunk lands.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_rdy[k] && w_v_in) begin
          r_ovf <= (SIGNED != 0) && (w_a_in[WIDTH-1] == w_b_in[WIDTH-1]) &&
                   (w_sum_new[WIDTH-1] != w_a_in[WIDTH-1]);
        end
      end

      assign ovf = r_ovf;
    end
  end

  // Operand bits of already-summed chunks are carried but never read again.
  assign w_unused_ops = ^{w_a_q, w_b_q};

  assign out_valid = w_valid_q[STAGES-1];
  assign sum       = w_sum_q[STAGES-1];
  assign cout      = w_carry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed checks on an 8-bit/4-stage signed adder plus randomized streaming
// on 32-bit instances with 4 stages and 1 stage against a reference sum.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic       d_ivld, d_irdy, d_cin, d_ovld, d_ordy, d_cout, d_ovf;
  logic [7:0] d_a, d_b, d_sum;

  pipelined_adder #(.WIDTH(8), .STAGES(4), .SIGNED(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_ivld), .in_ready(d_irdy),
    .a(d_a), .b(d_b), .cin(d_cin), .out_valid(d_ovld), .out_ready(d_ordy),
    .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
  );

  logic [1:0][31:0] x_a, x_b, x_sum;
  logic [1:0]       x_cin, x_ivld, x_irdy, x_ovld, x_ordy, x_cout, x_ovf;

  pipelined_adder #(.WIDTH(32), .STAGES(4), .SIGNED(0)) u_dut32_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_ivld[0]), .in_ready(x_irdy[0]),
    .a(x_a[0]), .b(x_b[0]), .cin(x_cin[0]), .out_valid(x_ovld[0]), .out_ready(x_ordy[0]),
    .sum(x_sum[0]), .cout(x_cout[0]), .ovf(x_ovf[0])
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1), .SIGNED(1)) u_dut32_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_ivld[1]), .in_ready(x_irdy[1]),
    .a(x_a[1]), .b(x_b[1]), .cin(x_cin[1]), .out_valid(x_ovld[1]), .out_ready(x_ordy[1]),
    .sum(x_sum[1]), .cout(x_cout[1]), .ovf(x_ovf[1])
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [9:0] e;   // {ovf, cout, sum}
  } vec_t;

  vec_t t3 [6] = '{
    '{8'h01, 8'h02, 1'b0, 10'h003},
    '{8'h10, 8'h20, 1'b1, 10'h031},
    '{8'hFF, 8'hFF, 1'b1, 10'h1FF},
    '{8'h7F, 8'h7F, 1'b0, 10'h2FE},
    '{8'hAA, 8'h55, 1'b0, 10'h0FF},
    '{8'h80, 8'h7F, 1'b1, 10'h100}
  };

  vec_t t4 [6] = '{
    '{8'h03, 8'h04, 1'b0, 10'h007},
    '{8'hF0, 8'h0F, 1'b1, 10'h100},
    '{8'h40, 8'h40, 1'b0, 10'h280},
    '{8'hC0, 8'hC0, 1'b0, 10'h180},
    '{8'h12, 8'h34, 1'b1, 10'h047},
    '{8'hFE, 8'h01, 1'b0, 10'h0FF}
  };

  logic [9:0]  exp8 [$];
  logic [9:0]  got8 [$];
  int          gcyc [$];
  logic [33:0] xq0  [$];
  logic [33:0] xq1  [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic signed_en);
    logic [32:0] s;
    logic        v;
    s = {1'b0, a} + {1'b0, b} + {32'd0, c};
    v = signed_en && (a[31] == b[31]) && (s[31] != a[31]);
    return {v, s};
  endfunction

  // Record every completed output transfer of the 8-bit instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && d_ovld === 1'b1 && d_ordy === 1'b1) begin
      got8.push_back({d_ovf, d_cout, d_sum});
      gcyc.push_back(cyc);
    end
  end

  // Called at posedge+1; holds the operand until an edge accepts it.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [9:0] e);
    bit ok;
    d_a = a; d_b = b; d_cin = c; d_ivld = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = d_irdy;
      @(posedge clk);
      #1;
      if (ok) begin
        exp8.push_back(e);
        d_ivld = 1'b0;
        return;
      end
    end
    check_val("send_timeout", 64'd1, 64'd0);
    d_ivld = 1'b0;
  endtask

  task automatic drain8(input string tag);
    for (int i = 0; i < 60 && got8.size() < exp8.size(); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check_val({tag, "_count"}, 64'(got8.size()), 64'(exp8.size()));
    for (int i = 0; i < exp8.size() && i < got8.size(); i++)
      check_val(tag, 64'(got8[i]), 64'(exp8[i]));
    got8.delete();
    exp8.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit [1:0]    acc;
    logic [33:0] got, e;
    string       tag;

    rst_n  = 1'b0;
    d_ivld = 1'b0; d_a = 8'h00; d_b = 8'h00; d_cin = 1'b0; d_ordy = 1'b1;
    x_a = '0; x_b = '0; x_cin = '0; x_ivld = '0; x_ordy = 2'b11;

    #12;
    check_val("rst_out_valid", 64'(d_ovld), 64'd0);
    check_val("rst_sum",       64'(d_sum),  64'd0);
    check_val("rst_cout",      64'(d_cout), 64'd0);
    check_val("rst_ovf",       64'(d_ovf),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_in_ready", 64'(d_irdy), 64'd1);

    // Test 1: wrap to zero with carry, valid exactly 4 edges after accept.
    d_a = 8'hFF; d_b = 8'h01; d_cin = 1'b0; d_ivld = 1'b1;
    exp8.push_back(10'h100);
    for (int ed = 1; ed <= 4; ed++) begin
      @(posedge clk);
      #1;
      d_ivld = 1'b0;
      @(negedge clk);
      check_val($sformatf("t1_valid_edge%0d", ed), 64'(d_ovld), 64'(ed == 4));
    end
    check_val("t1_result", 64'({d_ovf, d_cout, d_sum}), 64'h100);
    @(posedge clk);
    #1;
    drain8("t1");

    // Test 2: signed overflow cases.
    send8(8'h7F, 8'h01, 1'b0, 10'h280);
    send8(8'h80, 8'h80, 1'b0, 10'h300);
    drain8("t2");

    // Test 3: six back-to-back operations stream out on consecutive cycles.
    gcyc.delete();
    for (int i = 0; i < 6; i++) send8(t3[i].a, t3[i].b, t3[i].c, t3[i].e);
    drain8("t3");
    if (gcyc.size() == 6) check_val("t3_consecutive", 64'(gcyc[5] - gcyc[0]), 64'd5);
    else                  check_val("t3_out_count", 64'(gcyc.size()), 64'd6);

    // Test 4: back-pressure fills the pipe, holds outputs, then releases in order.
    d_ordy = 1'b0;
    for (int i = 0; i < 4; i++) send8(t4[i].a, t4[i].b, t4[i].c, t4[i].e);
    d_a = t4[4].a; d_b = t4[4].b; d_cin = t4[4].c; d_ivld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("t4_full_in_ready", 64'(d_irdy), 64'd0);
      check_val("t4_stall_valid",   64'(d_ovld), 64'd1);
      check_val("t4_stall_hold",    64'({d_ovf, d_cout, d_sum}), 64'h007);
      @(posedge clk);
      #1;
    end
    d_ordy = 1'b1;
    @(negedge clk);
    check_val("t4_release_in_ready", 64'(d_irdy), 64'd1);
    exp8.push_back(t4[4].e);
    @(posedge clk);
    #1;
    d_ivld = 1'b0;
    send8(t4[5].a, t4[5].b, t4[5].c, t4[5].e);
    drain8("t4");

    // Test 5: reset with three operations in flight discards them.
    d_ordy = 1'b0;
    send8(8'h01, 8'h01, 1'b0, 10'h002);
    send8(8'h02, 8'h02, 1'b0, 10'h004);
    send8(8'h03, 8'h03, 1'b0, 10'h006);
    @(posedge clk);
    #1;
    check_val("t5_pre_valid", 64'(d_ovld), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_valid", 64'(d_ovld), 64'd0);
    check_val("t5_rst_sum",   64'(d_sum),  64'd0);
    check_val("t5_rst_cout",  64'(d_cout), 64'd0);
    exp8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    d_ordy = 1'b1;
    @(negedge clk);
    check_val("t5_in_ready", 64'(d_irdy), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    check_val("t5_no_stale", 64'(got8.size()), 64'd0);
    send8(8'h05, 8'h06, 1'b0, 10'h00B);
    drain8("t5_after");

    // Test 6: randomized streaming on both 32-bit instances, then drain.
    for (int n = 0; n < 3030; n++) begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) begin
        if (x_ovld[id] && x_ordy[id]) begin
          got = {x_ovf[id], x_cout[id], x_sum[id]};
          if (id == 0) begin
            tag = "rand_s4";
            e   = (xq0.size() > 0) ? xq0.pop_front() : ~got;
          end else begin
            tag = "rand_s1";
            e   = (xq1.size() > 0) ? xq1.pop_front() : ~got;
          end
          check_val(tag, 64'(got), 64'(e));
        end
        acc[id] = x_ivld[id] & x_irdy[id];
        if (acc[id]) begin
          if (id == 0) xq0.push_back(model32(x_a[0], x_b[0], x_cin[0], 1'b0));
          else         xq1.push_back(model32(x_a[1], x_b[1], x_cin[1], 1'b1));
        end
      end
      @(posedge clk);
      #1;
      for (int id = 0; id < 2; id++) begin
        if (acc[id] || !x_ivld[id]) begin
          x_a[id]   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
          x_b[id]   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
          x_cin[id] = 1'($urandom_range(0, 1));
          x_ivld[id] = (n < 3000) && ($urandom_range(0, 3) != 0);
        end
        x_ordy[id] = (n >= 3000) || ($urandom_range(0, 3) != 0);
      end
    end
    check_val("rand_s4_left", 64'(xq0.size()), 64'd0);
    check_val("rand_s1_left", 64'(xq1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
